// File: rtl/mux_scan_sampler.sv
// Scan controller for a 4-to-1 mux: steps the select lines through channels 0..3,
// samples w after SETTLE cycles per channel and offers the 4-bit word over valid/ready.
module mux_scan_sampler #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       w,
    output logic       s0,
    output logic       s1,
    output logic [3:0] word,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] shift_q, shift_d;
    logic [3:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic [3:0] assembled;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        assembled = shift_q;

        // A consumed word clears valid; a word loaded on the same edge re-sets it below.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    ch_d      = 2'd0;
                    cnt_d     = 4'd0;
                    overrun_d = 1'b0;
                end
            end
            SCAN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = 4'd0;
                    assembled[ch_q] = w;
                    shift_d       = assembled;
                    ch_d          = ch_q + 2'd1;
                    if (ch_q == 2'd3) begin
                        // Drop the finished word if the previous one is still unconsumed.
                        if (!valid_q || ready) begin
                            word_d  = assembled;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        if (!continuous) begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= 2'd0;
            cnt_q     <= 4'd0;
            shift_q   <= 4'd0;
            word_q    <= 4'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign s0      = ch_q[0];
    assign s1      = ch_q[1];
    assign word    = word_q;
    assign valid   = valid_q;
    assign busy    = (state_q == SCAN);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Randomized bench for mux_scan_sampler: a behavioural Mpx4_1 feeds w, a cycle-level
// reference model predicts outputs and queues expected words for the scoreboard monitor.
module tb_mux_scan_sampler;

    localparam int SETTLE    = 2;
    localparam int SCAN_LEN  = 4 * SETTLE;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] d = 4'd0;
    logic       w;
    logic       s0, s1, valid, busy, overrun;
    logic [3:0] word;

    int errors = 0;
    int checks = 0;

    mux_scan_sampler #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .w          (w),
        .s0         (s0),
        .s1         (s1),
        .word       (word),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Behavioural Mpx4_1
    assign w = d[{s1, s0}];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks elapsed cycles in the current scan rather than channel/counter.
    bit       m_busy = 0;
    int       m_el = 0;
    bit       m_valid = 0;
    bit       m_overrun = 0;
    logic [3:0] m_word = 4'd0;
    logic [3:0] m_part = 4'd0;
    logic [3:0] exp_q[$];

    bit m_can_load;
    bit m_xfer;
    int m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    = 0;
            m_el      = 0;
            m_valid   = 0;
            m_overrun = 0;
            m_word    = 4'd0;
            m_part    = 4'd0;
            exp_q.delete();
        end else begin
            m_xfer     = m_valid && ready;
            m_can_load = !m_valid || m_xfer;
            if (m_xfer) m_valid = 0;
            if (m_busy) begin
                m_k = m_el / SETTLE;
                if ((m_el % SETTLE) == SETTLE - 1) m_part[m_k] = d[m_k];
                m_el++;
                if (m_el == SCAN_LEN) begin
                    if (m_can_load) begin
                        m_word  = m_part;
                        m_valid = 1;
                        exp_q.push_back(m_part);
                    end else begin
                        m_overrun = 1;
                    end
                    m_el = 0;
                    if (!continuous) m_busy = 0;
                end
            end else if (start) begin
                m_busy    = 1;
                m_el      = 0;
                m_overrun = 0;
            end
        end
    end

    // Per-cycle output checks plus scoreboard pop on each handshake, mid-cycle.
    logic [3:0] got_word;
    always @(negedge clk) begin
        check("select", {30'd0, s1, s0}, m_busy ? 32'((m_el / SETTLE) % 4) : 32'd0);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("valid", {31'd0, valid}, {31'd0, m_valid});
        check("overrun", {31'd0, overrun}, {31'd0, m_overrun});
        check("word", {28'd0, word}, {28'd0, m_word});
        if (valid === 1'b1 && ready === 1'b1) begin
            got_word = word;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                check("sb_word", {28'd0, got_word}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic single_shot(input logic [3:0] dv);
        d          = dv;
        ready      = 1'b1;
        continuous = 1'b0;
        start      = 1'b1;
        cycles(1);
        start      = 1'b0;
        cycles(SCAN_LEN + 3);
    endtask

    logic [3:0] sweep [6];

    initial begin
        sweep[0] = 4'b0001; sweep[1] = 4'b0010; sweep[2] = 4'b0100;
        sweep[3] = 4'b1000; sweep[4] = 4'b1111; sweep[5] = 4'b0000;

        #1 rst = 1'b1;
        #2;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_word", {28'd0, word}, 32'd0);
        cycles(2);
        rst = 1'b0;
        cycles(2);

        // Single shot, then sweep of patterns.
        single_shot(4'b0100);
        for (int i = 0; i < 6; i++) single_shot(sweep[i]);
        check("sweep_no_overrun", {31'd0, overrun}, 32'd0);

        // Continuous with stalled consumer: second completion overruns.
        d = 4'b1010; ready = 1'b0; continuous = 1'b1; start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(2 * SCAN_LEN);
        check("ovr_word_kept", {28'd0, word}, 32'hA);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        cycles(1);
        check("ovr_valid_cleared", {31'd0, valid}, 32'd0);
        continuous = 1'b0;
        cycles(SCAN_LEN + 3);

        // Continuous with ready held: back-to-back words.
        d = 4'b0011; ready = 1'b1; continuous = 1'b1; start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(5 * SCAN_LEN);
        continuous = 1'b0;
        cycles(SCAN_LEN + 2);

        // Reset mid-scan must clear outputs before the next edge.
        d = 4'b0110; ready = 1'b0; start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(4);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_select", {30'd0, s1, s0}, 32'd0);
        check("arst_word", {28'd0, word}, 32'd0);
        cycles(2);
        rst = 1'b0;
        cycles(SCAN_LEN);
        single_shot(4'b0100);

        // Start held through a scan: IDLE for one cycle, then a new scan.
        d = 4'b1001; ready = 1'b1; continuous = 1'b0; start = 1'b1;
        cycles(2 * SCAN_LEN + 4);
        start = 1'b0;
        cycles(SCAN_LEN + 2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            d          = 4'($urandom);
            start      = ($urandom_range(0, 7) == 0);
            ready      = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) continuous = ~continuous;
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end
            cycles(1);
        end

        // Drain: every predicted word must have been consumed.
        start = 1'b0; continuous = 1'b0; ready = 1'b1;
        cycles(2 * SCAN_LEN + 4);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Scan controller paired with the 4-to-1 multiplexer (Mpx4_1).
- Drives the mux select lines s0/s1 through channels 0..3 and samples the mux output w after a programmable settle time.
- Assembles the four samples into a 4-bit word and offers it to a downstream consumer over a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- SETTLE, 2: cycles each select value is held before w is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a scan (sampled in IDLE only)
- continuous  input  1  when high, a finished scan immediately starts another
- w  input  1  mux output being sampled
- s0  output  1  mux select LSB, equals ch[0]
- s1  output  1  mux select MSB, equals ch[1]
- word  output  4  assembled sample word; bit k = w sampled while select = k
- valid  output  1  word holds an unconsumed result
- ready  input  1  consumer accepts word on a cycle where valid && ready
- busy  output  1  scan in progress
- overrun  output  1  sticky; a completed scan was dropped because the previous word was unconsumed

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values (immediately on rst high, independent of clk):
  - state=IDLE, ch=0, settle counter=0, shift register=0
  - s0=0, s1=0, word=0, valid=0, busy=0, overrun=0
- States: IDLE, SCAN.
- IDLE:
  - start=1 at a clock edge -> SCAN, ch=0, counter=0, busy=1.
  - overrun is cleared on that same edge.
- SCAN: each channel occupies exactly SETTLE cycles.
  - Counter increments every edge.
  - On the edge where counter==SETTLE-1, w is captured into shift bit ch, the counter resets, and ch increments (wraps 3->0).
- Scan completion (edge capturing ch=3):
  - If valid=0, or valid&&ready on that same edge: word <= assembled bits including the current w, valid=1.
  - Otherwise: the word is dropped, word is unchanged, overrun=1.
  - Then, if continuous=1, stay in SCAN with ch=0 (no idle cycle). Else go to IDLE, busy=0, ch=0.
- Latency: start edge to valid high = 4*SETTLE cycles. For SETTLE=2, valid rises on the 8th edge after the start edge.
- Handshake:
  - valid stays high and word stays stable until an edge with ready=1.
  - On that edge valid clears, unless a new word loads on the same edge, in which case valid stays 1 with the new word.
  - ready while valid=0 has no effect.
- start while in SCAN is ignored.
- continuous sampled only at scan completion. Dropping it mid-scan finishes the current scan and then goes to IDLE.
- s0/s1 are registered outputs and change only on channel-advance edges. w is sampled SETTLE cycles after the select changes, which allows mux propagation.
- Reset mid-scan aborts immediately. The partial word is discarded, and a pending valid word is lost.

Test Plan:
- Single shot, SETTLE=2, behavioural Mpx4_1 with d=4'b0100, pulse start, ready=1 -> s1s0 steps 00,01,10,11 every 2 cycles; valid high 1 cycle at edge 8 with word=4'b0100; busy low afterwards.
- Sweep d over 0001, 0010, 0100, 1000, 1111, 0000, one single-shot scan each -> word equals d every time; overrun stays 0.
- Continuous=1, ready=0, d=4'b1010 -> first word 1010 valid at edge 8; second completion at edge 16 sets overrun=1 while word stays 1010; raising ready then clears valid; the next scan loads a fresh word.
- Continuous=1, ready=1 held, d=4'b0011 -> valid asserts on every scan-completion edge; no idle cycle between scans; words of 0011 arrive every 8 cycles; overrun=0.
- Assert rst at cycle 5 of a scan -> outputs go to zero asynchronously before the next edge; no valid afterwards; a new start behaves like the first scenario.
- Start held high through a whole scan with continuous=0 -> exactly one scan, one IDLE cycle, then a new scan begins (start re-sampled in IDLE).
